seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_pkg.sv | 33 +++
 rtl/seven_seg_scanner_seg_decode.sv | 35 +++
 rtl/seven_seg_scanner.sv | 189 ++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: FSM states, segment
// codes (active-low {a,b,c,d,e,f,g}) and the dark/blank output constants.
package seven_seg_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // A blanked digit and the dark cathode bus are the same pattern.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] CAT_OFF   = 7'h7F;
    localparam logic       DP_OFF    = 1'b1;

endpackage

// File: rtl/seven_seg_scanner_seg_decode.sv
// seg_decode: 4-bit digit code to active-low segment pattern. Codes 10..15
// render as A..F only when hex_mode is set, otherwise they are blank.
module seg_decode
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [6:0] cat
);

    // Pure lookup; every code has a defined pattern.
    always_comb begin
        cat = SEG_BLANK;
        case (code)
            4'h0: cat = SEG_0;
            4'h1: cat = SEG_1;
            4'h2: cat = SEG_2;
            4'h3: cat = SEG_3;
            4'h4: cat = SEG_4;
            4'h5: cat = SEG_5;
            4'h6: cat = SEG_6;
            4'h7: cat = SEG_7;
            4'h8: cat = SEG_8;
            4'h9: cat = SEG_9;
            4'hA: cat = hex_mode ? SEG_A : SEG_BLANK;
            4'hB: cat = hex_mode ? SEG_B : SEG_BLANK;
            4'hC: cat = hex_mode ? SEG_C : SEG_BLANK;
            4'hD: cat = hex_mode ? SEG_D : SEG_BLANK;
            4'hE: cat = hex_mode ? SEG_E : SEG_BLANK;
            4'hF: cat = hex_mode ? SEG_F : SEG_BLANK;
            default: cat = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment driver with guard intervals
// between digits and frame-synchronous display updates (no torn frames).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Handshake: load is a one-cycle strobe with no back-pressure; pending stays
// high from the captured load until the shadow reaches the display register.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_TICKS = 1,
    parameter int DWELL_TICKS = 3,
    parameter int HEX_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              cat,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output scan_state_e             fsm_state
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W   = $clog2(REFRESH_DIV);
    localparam int TC_MAX = (GUARD_TICKS > DWELL_TICKS) ? GUARD_TICKS : DWELL_TICKS;
    localparam int TC_W   = (TC_MAX > 1) ? $clog2(TC_MAX) : 1;

    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TC_W-1:0]  GUARD_LAST = TC_W'(GUARD_TICKS - 1);
    localparam logic [TC_W-1:0]  DWELL_LAST = TC_W'(DWELL_TICKS - 1);

    scan_state_e             state;
    logic [PS_W-1:0]         ps_cnt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        next_idx;
    logic [TC_W-1:0]         tcnt;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    tick;
    logic                    enter_frame;
    logic                    xfer;
    logic [3:0]              digit_code;
    logic [6:0]              dec_cat;
    logic [6:0]              sel_cat;
    logic                    sel_dp;
    logic [NUM_DIGITS-1:0]   an_sel;

    assign fsm_state = state;

    // Tick, frame-boundary detection and selected-digit data.
    always_comb begin
        tick        = (ps_cnt == PS_LAST);
        next_idx    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        // A new frame starts when GUARD is entered with digit 0.
        enter_frame = enable && tick &&
                      ((state == IDLE) ||
                       ((state == DRIVE) && (tcnt == DWELL_LAST) && (idx == LAST_IDX)));
        // While idle there is no frame to tear, so update immediately.
        xfer        = enter_frame || ((state == IDLE) && pending);
        digit_code  = disp_val[{idx, 2'b00} +: 4];
        sel_dp      = disp_dp[idx];
        an_sel      = ~(NUM_DIGITS'(1) << idx);
    end

    seg_decode u_seg_decode (
        .code     (digit_code),
        .hex_mode (HEX_MODE != 0),
        .cat      (dec_cat)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_above;

    // A digit above 0 is blank when it and every higher digit are zero.
    always_comb begin
        zero_above = 1'b1;
        lead_zero  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (disp_val[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_above;
        end
    end

    assign sel_cat = lead_zero[idx] ? SEG_BLANK : dec_cat;
`else
    assign sel_cat = dec_cat;
`endif

    // Free-running prescaler producing one tick per REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // Shadow capture and frame-synchronous transfer; a load on the transfer
    // edge wins the shadow while the older shadow moves to the display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            if (xfer) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (xfer) begin
                pending    <= 1'b0;
            end
        end
    end

    // Scan FSM with registered anode/cathode outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            tcnt  <= '0;
            an    <= '1;
            cat   <= CAT_OFF;
            dp_n  <= DP_OFF;
        end else if (!enable) begin
            state <= IDLE;
            idx   <= '0;
            tcnt  <= '0;
            an    <= '1;
            cat   <= CAT_OFF;
            dp_n  <= DP_OFF;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    state <= GUARD;
                    idx   <= '0;
                    tcnt  <= '0;
                end
                GUARD: begin
                    if (tcnt == GUARD_LAST) begin
                        state <= DRIVE;
                        tcnt  <= '0;
                        an    <= an_sel;
                        cat   <= sel_cat;
                        dp_n  <= ~sel_dp;
                    end else begin
                        tcnt  <= tcnt + TC_W'(1);
                    end
                end
                DRIVE: begin
                    if (tcnt == DWELL_LAST) begin
                        state <= GUARD;
                        idx   <= next_idx;
                        tcnt  <= '0;
                        an    <= '1;
                        cat   <= CAT_OFF;
                        dp_n  <= DP_OFF;
                    end else begin
                        tcnt  <= tcnt + TC_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    an    <= '1;
                    cat   <= CAT_OFF;
                    dp_n  <= DP_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: two instances share all inputs, one
// with HEX_MODE=0 and one with HEX_MODE=1. Expected {an,cat,dp_n} per digit
// are hand-written constants queued ahead of each frame.
module tb_seven_seg_scanner;
    import seven_seg_scanner_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0]  cat, cat_hex;
    logic        dp_n, dp_n_hex;
    logic [3:0]  an, an_hex;
    logic        pending, pending_hex;
    scan_state_e fsm_state, fsm_state_hex;

    int n_checks = 0;
    int n_pass   = 0;
    int onehot_viol = 0;

    logic [11:0] exp_q[$];   // {an, cat, dp_n}
    logic [6:0]  hex_q[$];   // cat of the HEX_MODE=1 instance

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(2), .GUARD_TICKS(1), .DWELL_TICKS(1), .HEX_MODE(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .cat(cat), .dp_n(dp_n), .an(an), .pending(pending),
        .fsm_state(fsm_state)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(2), .GUARD_TICKS(1), .DWELL_TICKS(1), .HEX_MODE(1)
    ) dut_hex (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .cat(cat_hex), .dp_n(dp_n_hex), .an(an_hex), .pending(pending_hex),
        .fsm_state(fsm_state_hex)
    );

    // Anodes must never be multi-hot on either instance.
    always @(negedge clk) begin
        if (!reset && ($countones(~an) > 1 || $countones(~an_hex) > 1))
            onehot_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Waits through the guard gap into the next lit digit; called at a negedge.
    task automatic next_drive(output logic ok);
        int n;
        ok = 1'b1;
        n = 0;
        while (an !== 4'hF && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) ok = 1'b0;
        n = 0;
        while (an === 4'hF && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) ok = 1'b0;
    endtask

    // Reads cnt lit digits and compares each against the expected queues.
    task automatic read_frame(input string tag, input int cnt);
        logic        ok;
        logic [11:0] e;
        for (int i = 0; i < cnt; i++) begin
            next_drive(ok);
            check({tag, "_wait"}, ok, 1'b1);
            e = exp_q.pop_front();
            check(tag, {an, cat, dp_n}, e);
            if (hex_q.size() > 0) check({tag, "_hex"}, cat_hex, hex_q.pop_front());
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Disable, load while idle, let the idle transfer happen, re-enable.
    task automatic reload_idle(input logic [15:0] v, input logic [3:0] d);
        enable = 1'b0;
        @(negedge clk);
        do_load(v, d);
        @(negedge clk);
        enable = 1'b1;
    endtask

    initial begin
        logic ok;
        reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_cat", cat, 7'h7F);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_an", an, 4'hF);
        check("rst_pending", pending, 1'b0);
        check("rst_state", fsm_state, IDLE);
        reset = 1'b0;
        @(negedge clk);

        // Load 1234 while idle: pending rises, then idle transfer clears it.
        do_load(16'h1234, 4'b0100);
        check("ld_pending_set", pending, 1'b1);
        @(negedge clk);
        check("ld_pending_clr", pending, 1'b0);
        enable = 1'b1;
        exp_q.push_back({4'b1110, 7'b1001100, 1'b1});
        exp_q.push_back({4'b1101, 7'b0000110, 1'b1});
        exp_q.push_back({4'b1011, 7'b0010010, 1'b0});
        exp_q.push_back({4'b0111, 7'b1001111, 1'b1});
        read_frame("f1234", 4);

        // Mid-frame load of 5678: current frame completes with 1234.
        exp_q.push_back({4'b1110, 7'b1001100, 1'b1});
        read_frame("f1234b_d0", 1);
        do_load(16'h5678, 4'b0001);
        check("mid_pending_set", pending, 1'b1);
        exp_q.push_back({4'b1101, 7'b0000110, 1'b1});
        exp_q.push_back({4'b1011, 7'b0010010, 1'b0});
        exp_q.push_back({4'b0111, 7'b1001111, 1'b1});
        read_frame("f1234b", 3);
        check("mid_pending_hold", pending, 1'b1);
        exp_q.push_back({4'b1110, 7'b0000000, 1'b0});
        exp_q.push_back({4'b1101, 7'b0001111, 1'b1});
        exp_q.push_back({4'b1011, 7'b0100000, 1'b1});
        exp_q.push_back({4'b0111, 7'b0100100, 1'b1});
        read_frame("f5678", 4);
        check("f5678_pending", pending, 1'b0);

        // Disable mid-drive: dark on the next cycle.
        exp_q.push_back({4'b1110, 7'b0000000, 1'b0});
        read_frame("f5678b_d0", 1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_an", an, 4'hF);
        check("dis_cat", cat, 7'h7F);
        check("dis_dp_n", dp_n, 1'b1);
        check("dis_state", fsm_state, IDLE);

        // Hex codes: blank without hex mode, A..F with it.
        reload_idle(16'hABCD, 4'b0000);
        exp_q.push_back({4'b1110, 7'h7F, 1'b1});
        exp_q.push_back({4'b1101, 7'h7F, 1'b1});
        exp_q.push_back({4'b1011, 7'h7F, 1'b1});
        exp_q.push_back({4'b0111, 7'h7F, 1'b1});
        hex_q.push_back(7'b1000010);
        hex_q.push_back(7'b0110001);
        hex_q.push_back(7'b1100000);
        hex_q.push_back(7'b0001000);
        read_frame("fABCD", 4);

        // Leading zeros.
        reload_idle(16'h0070, 4'b0000);
        exp_q.push_back({4'b1110, 7'b0000001, 1'b1});
        exp_q.push_back({4'b1101, 7'b0001111, 1'b1});
`ifdef LEADING_ZERO_BLANK_EN
        exp_q.push_back({4'b1011, 7'h7F, 1'b1});
        exp_q.push_back({4'b0111, 7'h7F, 1'b1});
`else
        exp_q.push_back({4'b1011, 7'b0000001, 1'b1});
        exp_q.push_back({4'b0111, 7'b0000001, 1'b1});
`endif
        read_frame("f0070", 4);

        reload_idle(16'h0000, 4'b0000);
        exp_q.push_back({4'b1110, 7'b0000001, 1'b1});
`ifdef LEADING_ZERO_BLANK_EN
        exp_q.push_back({4'b1101, 7'h7F, 1'b1});
        exp_q.push_back({4'b1011, 7'h7F, 1'b1});
        exp_q.push_back({4'b0111, 7'h7F, 1'b1});
`else
        exp_q.push_back({4'b1101, 7'b0000001, 1'b1});
        exp_q.push_back({4'b1011, 7'b0000001, 1'b1});
        exp_q.push_back({4'b0111, 7'b0000001, 1'b1});
`endif
        read_frame("f0000", 4);

        // Asynchronous reset during the drive of digit 2.
        reload_idle(16'h1234, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            next_drive(ok);
            check("rst2_wait", ok, 1'b1);
        end
        check("rst2_an_before", an, 4'b1011);
        #2 reset = 1'b1;
        #1;
        check("rst2_an", an, 4'hF);
        check("rst2_cat", cat, 7'h7F);
        check("rst2_dp_n", dp_n, 1'b1);
        check("rst2_pending", pending, 1'b0);
        check("rst2_state", fsm_state, IDLE);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back({4'b1110, 7'b0000001, 1'b1});
        read_frame("rst2_first", 1);

        check("an_onehot_viol", onehot_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
